projectiles_allocator: RTL and testbench

Manages the projectile slot pool that feeds the projectile drawing chain. Accepts player and enemy fire requests, claims the lowest-indexed free slot in the matching group, issues a one-cycle launch pulse to that slot's projectile object, and tracks each slot's active lifetime until collision, off-screen exit or timeout frees it. Slot ordering is enemy slots `0..ENEMY_PROJECTILES-1`, then player slots above them. This is the same index order the projectile RGB mux uses for draw priority.

---
 rtl/projectiles_pkg.sv | 12 +
 rtl/projectiles_slot_finder.sv | 29 ++
 rtl/projectiles_allocator.sv | 114 +++++++++++
 tb/tb_projectiles_allocator.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/projectiles_pkg.sv
// Shared slot-pool definitions for the projectile allocator, RGB mux and projectile objects.
// Slot order is enemy slots first, then player slots. The RGB mux uses the same order for draw priority.
package projectiles_pkg;
   localparam int ENEMY_PROJECTILES  = 8;
   localparam int PLAYER_PROJECTILES = 4;
   localparam int NUM_PROJECTILES    = ENEMY_PROJECTILES + PLAYER_PROJECTILES;

   typedef logic [NUM_PROJECTILES-1:0] slot_vec_t;
   typedef logic [7:0]                 age_t;

   localparam age_t AGE_MAX = 8'd255;
endpackage

// File: rtl/projectiles_slot_finder.sv
// Lowest-index-first priority encoder over a free-slot mask.
// Produces a one-hot grant and a flag that is set when any slot is free.
module projectiles_slot_finder #(
   parameter int W = 4
) (
   input  logic [W-1:0] free,
   output logic [W-1:0] grant,
   output logic         any_free
);

   logic found_s;

   // pick the lowest set bit of the free mask
   always_comb begin
      grant   = '0;
      found_s = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (free[i] && !found_s) begin
            grant[i] = 1'b1;
            found_s  = 1'b1;
         end else begin
            grant[i] = grant[i];
         end
      end
   end

   assign any_free = |free;

endmodule

// File: rtl/projectiles_allocator.sv
// Projectile slot pool: claims the lowest free slot per group on fire requests and pulses launch.
// Also tracks each slot's lifetime until collision, off-screen exit or timeout releases it.
module projectiles_allocator
   import projectiles_pkg::*;
#(
   parameter int LIFETIME_FRAMES = 120,
   parameter int PLAYER_COOLDOWN = 10
) (
   input  logic      clk,
   input  logic      resetN,
   input  logic      startOfFrame,
   input  logic      playerFire,
   input  logic      enemyFire,
   input  slot_vec_t collision,
   input  slot_vec_t offScreen,
   output slot_vec_t launch,
   output slot_vec_t active,
   output logic      playerReady,
   output logic      enemyFull,
   output logic      dropped
);

   localparam age_t LIFETIME_LAST = age_t'(LIFETIME_FRAMES - 1);
   localparam age_t COOLDOWN_LOAD = age_t'(PLAYER_COOLDOWN);

   slot_vec_t                        active_r;
   slot_vec_t                        launch_r;
   logic                             dropped_r;
   age_t                             age_r [NUM_PROJECTILES];
   age_t                             cooldown_r;

   logic [ENEMY_PROJECTILES-1:0]     enemy_grant_s;
   logic [PLAYER_PROJECTILES-1:0]    player_grant_s;
   logic                             enemy_any_free_s;
   logic                             player_any_free_s;
   logic                             player_accept_s;
   logic                             enemy_accept_s;
   slot_vec_t                        launch_s;
   slot_vec_t                        release_s;

   // allocation looks only at the registered active vector, so a slot released this cycle is not reused until next cycle
   projectiles_slot_finder #(.W(ENEMY_PROJECTILES)) u_enemy_finder (
      .free     (~active_r[ENEMY_PROJECTILES-1:0]),
      .grant    (enemy_grant_s),
      .any_free (enemy_any_free_s)
   );

   projectiles_slot_finder #(.W(PLAYER_PROJECTILES)) u_player_finder (
      .free     (~active_r[NUM_PROJECTILES-1:ENEMY_PROJECTILES]),
      .grant    (player_grant_s),
      .any_free (player_any_free_s)
   );

   assign playerReady     = player_any_free_s && (cooldown_r == 8'd0);
   assign enemyFull       = ~enemy_any_free_s;
   assign player_accept_s = playerFire && playerReady;
   assign enemy_accept_s  = enemyFire && enemy_any_free_s;
   assign launch_s        = {{PLAYER_PROJECTILES{player_accept_s}} & player_grant_s,
                             {ENEMY_PROJECTILES{enemy_accept_s}} & enemy_grant_s};

   // per-slot release requests, masked to in-flight slots
   always_comb begin
      release_s = '0;
      for (int i = 0; i < NUM_PROJECTILES; i++) begin
         release_s[i] = active_r[i] & (collision[i] | offScreen[i] |
                                       (startOfFrame & (age_r[i] == LIFETIME_LAST)));
      end
   end

   // slot state, launch/drop pulses and player cooldown
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         active_r   <= '0;
         launch_r   <= '0;
         dropped_r  <= 1'b0;
         cooldown_r <= 8'd0;
      end else begin
         active_r  <= (active_r & ~release_s) | launch_s;
         launch_r  <= launch_s;
         dropped_r <= enemyFire && !enemy_any_free_s;
         if (player_accept_s) begin
            cooldown_r <= COOLDOWN_LOAD;
         end else if (startOfFrame && (cooldown_r != 8'd0)) begin
            cooldown_r <= cooldown_r - 8'd1;
         end else begin
            cooldown_r <= cooldown_r;
         end
      end
   end

   // per-slot frame age, cleared on launch and saturating at the top
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < NUM_PROJECTILES; i++) begin
            age_r[i] <= 8'd0;
         end
      end else begin
         for (int i = 0; i < NUM_PROJECTILES; i++) begin
            if (launch_s[i]) begin
               age_r[i] <= 8'd0;
            end else if (startOfFrame && active_r[i] && (age_r[i] != AGE_MAX)) begin
               age_r[i] <= age_r[i] + 8'd1;
            end else begin
               age_r[i] <= age_r[i];
            end
         end
      end
   end

   assign launch  = launch_r;
   assign active  = active_r;
   assign dropped = dropped_r;

endmodule

// File: tb/tb_projectiles_allocator.sv
// Scoreboard bench for projectiles_allocator (LIFETIME_FRAMES=4, PLAYER_COOLDOWN=10).
// Stimulus pushes the expected post-edge outputs, and a monitor pops and compares them after each edge.
module tb_projectiles_allocator;
   import projectiles_pkg::*;

   typedef struct packed {
      logic [15:0] id;
      slot_vec_t   launch;
      slot_vec_t   active;
      logic        drop;
      logic        ready;
      logic        full;
   } exp_t;

   logic      clk = 1'b0;
   logic      resetN = 1'b0;
   logic      startOfFrame = 1'b0;
   logic      playerFire = 1'b0;
   logic      enemyFire = 1'b0;
   slot_vec_t collision = '0;
   slot_vec_t offScreen = '0;
   slot_vec_t launch;
   slot_vec_t active;
   logic      playerReady;
   logic      enemyFull;
   logic      dropped;

   int   errors = 0;
   int   checks = 0;
   int   step_id = 0;
   exp_t q[$];

   projectiles_allocator #(.LIFETIME_FRAMES(4), .PLAYER_COOLDOWN(10)) dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .playerFire   (playerFire),
      .enemyFire    (enemyFire),
      .collision    (collision),
      .offScreen    (offScreen),
      .launch       (launch),
      .active       (active),
      .playerReady  (playerReady),
      .enemyFull    (enemyFull),
      .dropped      (dropped)
   );

   always #5 clk = ~clk;

   // monitor: after every edge, compare against the oldest pending expectation
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if ({launch, active, dropped, playerReady, enemyFull} !==
             {e.launch, e.active, e.drop, e.ready, e.full}) begin
            errors++;
            $display("FAIL step%0d: got launch=%h active=%h drop=%b ready=%b full=%b, want launch=%h active=%h drop=%b ready=%b full=%b",
                     e.id, launch, active, dropped, playerReady, enemyFull,
                     e.launch, e.active, e.drop, e.ready, e.full);
         end
      end
   end

   task automatic cyc(input logic pf, input logic ef, input logic sof,
                      input slot_vec_t col, input slot_vec_t off,
                      input slot_vec_t xl, input slot_vec_t xa,
                      input logic xd, input logic xr, input logic xf);
      exp_t e;
      @(negedge clk);
      playerFire   = pf;
      enemyFire    = ef;
      startOfFrame = sof;
      collision    = col;
      offScreen    = off;
      step_id++;
      e.id = 16'(step_id);
      e.launch = xl; e.active = xa; e.drop = xd; e.ready = xr; e.full = xf;
      q.push_back(e);
   endtask

   task automatic check_reset(input string name);
      checks++;
      if ({launch, active, dropped, playerReady, enemyFull} !== {12'h000, 12'h000, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL %s: got launch=%h active=%h drop=%b ready=%b full=%b, want 000 000 0 1 0",
                  name, launch, active, dropped, playerReady, enemyFull);
      end
   endtask

   initial begin
      slot_vec_t acc;
      #1;
      check_reset("reset_values");
      repeat (2) @(negedge clk);
      resetN = 1'b1;

      // single player fire, then cooldown blocks a fire three frames later
      cyc(1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 12'h100, 12'h100, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 12'h000, 12'h100, 1'b0, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, 1'b0, 1'b1, 12'h000, 12'h000, 12'h000, 12'h100, 1'b0, 1'b0, 1'b0);
      // ignored fire; offScreen on inactive slot 9 has no effect
      cyc(1'b1, 1'b0, 1'b0, 12'h000, 12'h200, 12'h000, 12'h100, 1'b0, 1'b0, 1'b0);
      // fourth frame since launch expires slot 8
      cyc(1'b0, 1'b0, 1'b1, 12'h000, 12'h000, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0);

      // enemy fire held 10 cycles from empty
      acc = '0;
      for (int k = 0; k < 8; k++) begin
         acc[k] = 1'b1;
         cyc(1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 12'h001 << k, acc, 1'b0, 1'b0, (k == 7));
      end
      repeat (2) cyc(1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 12'h000, 12'h0FF, 1'b1, 1'b0, 1'b1);

      // collision on slot 3 while full and firing: drop now, relaunch slot 3 next cycle
      cyc(1'b0, 1'b1, 1'b0, 12'h008, 12'h000, 12'h000, 12'h0F7, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 12'h008, 12'h0FF, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 12'h000, 12'h0FF, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 12'h0FF, 12'h000, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0);

      // burn the remaining six cooldown frames
      repeat (5) cyc(1'b0, 1'b0, 1'b1, 12'h000, 12'h000, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 12'h000, 12'h000, 12'h000, 12'h000, 1'b0, 1'b1, 1'b0);

      // both groups fire together from empty
      cyc(1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 12'h101, 12'h101, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 12'h002, 12'h103, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 12'h004, 12'h107, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 12'h008, 12'h10F, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #2;

      // asynchronous reset with five slots in flight
      @(negedge clk);
      playerFire = 1'b0; enemyFire = 1'b0; startOfFrame = 1'b0;
      collision = '0; offScreen = '0;
      #2 resetN = 1'b0;
      #1 check_reset("async_reset");
      @(negedge clk);
      check_reset("reset_held");
      resetN = 1'b1;
      cyc(1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 12'h001, 12'h001, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 12'h000, 12'h001, 1'b0, 1'b1, 1'b0);

      for (int t = 0; t < 20 && q.size() > 0; t++) @(posedge clk);
      #3;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
